// File: rtl/rgb_led_sequencer.sv
// rtl/rgb_led_sequencer.sv - switch-driven RGB LED mode sequencer with debounce and PWM dimming
module rgb_led_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1250000,
    parameter int unsigned STEP_CYCLES     = 62500000,
    parameter int unsigned PWM_BITS        = 8,
    parameter int unsigned DUTY            = 32
) (
    input  logic       clk_125,
    input  logic       rst_n,
    input  logic [1:0] sw,
    output logic       ld4_r_n,
    output logic       ld4_g_n,
    output logic       ld4_b_n,
    output logic       ld5_r_n,
    output logic       ld5_g_n,
    output logic       ld5_b_n,
    output logic [2:0] state_o
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int ST_W = $clog2(STEP_CYCLES + 1);
    localparam logic [DB_W-1:0]     DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ST_W-1:0]     STEP_LAST = ST_W'(STEP_CYCLES - 1);
    localparam logic [PWM_BITS-1:0] DUTY_V    = PWM_BITS'(DUTY);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_STATIC = 3'd1,
        ST_CYC_R  = 3'd2,
        ST_CYC_G  = 3'd3,
        ST_CYC_B  = 3'd4
    } state_t;

    logic [1:0]          sw_m;
    logic [1:0]          sw_s;
    logic [1:0]          sw_db;
    logic [DB_W-1:0]     db_cnt [2];
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                pwm_on;
    logic [ST_W-1:0]     step_cnt;
    state_t              state;
    state_t              next_colour;
    logic [5:0]          lit;
    logic [5:0]          led_q;

    always_ff @(posedge clk_125 or negedge rst_n) begin
        if (!rst_n) begin
            sw_m <= '0;
            sw_s <= '0;
        end else begin
            sw_m <= sw;
            sw_s <= sw_m;
        end
    end

    // Any agreement with the stable value restarts the count, so short glitches are dropped.
    always_ff @(posedge clk_125 or negedge rst_n) begin
        if (!rst_n) begin
            sw_db     <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sw_s[i] == sw_db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    sw_db[i]  <= sw_s[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_125 or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    assign pwm_on = (pwm_cnt < DUTY_V);

    // lit bit order: {ld4_r, ld4_g, ld4_b, ld5_r, ld5_g, ld5_b}
    always_comb begin
        lit         = 6'b000000;
        next_colour = ST_CYC_R;
        case (state)
            ST_STATIC: lit = 6'b001001;
            ST_CYC_R: begin
                lit         = 6'b100010;
                next_colour = ST_CYC_G;
            end
            ST_CYC_G: begin
                lit         = 6'b010001;
                next_colour = ST_CYC_B;
            end
            ST_CYC_B: begin
                lit         = 6'b001100;
                next_colour = ST_CYC_R;
            end
            default: begin
                lit         = 6'b000000;
                next_colour = ST_CYC_R;
            end
        endcase
    end

    always_ff @(posedge clk_125 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            step_cnt <= '0;
            led_q    <= '1;
        end else begin
            led_q <= pwm_on ? ~lit : 6'b111111;
            if (state > ST_CYC_B) begin
                state    <= ST_IDLE;
                step_cnt <= '0;
            end else if (!sw_db[0]) begin
                state    <= ST_IDLE;
                step_cnt <= '0;
            end else if (!sw_db[1]) begin
                state    <= ST_STATIC;
                step_cnt <= '0;
            end else begin
                case (state)
                    ST_CYC_R, ST_CYC_G, ST_CYC_B: begin
                        if (step_cnt == STEP_LAST) begin
                            state    <= next_colour;
                            step_cnt <= '0;
                        end else begin
                            step_cnt <= step_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state    <= ST_CYC_R;
                        step_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign ld4_r_n = led_q[5];
    assign ld4_g_n = led_q[4];
    assign ld4_b_n = led_q[3];
    assign ld5_r_n = led_q[2];
    assign ld5_g_n = led_q[1];
    assign ld5_b_n = led_q[0];
    assign state_o = state;

endmodule

// File: tb/tb_rgb_led_sequencer.sv
// tb/tb_rgb_led_sequencer.sv - self-checking bench for rgb_led_sequencer against a behavioural model
module tb_rgb_led_sequencer;

    localparam int D      = 4;
    localparam int STEP   = 16;
    localparam int PERIOD = 8;
    localparam int DUTY_A = 4;
    localparam int DUTY_Z = 0;
    localparam int DUTY_F = 7;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] sw    = 2'b00;
    wire  [5:0] out_a, out_z, out_f;
    wire  [2:0] st_a, st_z, st_f;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] hist[$];
    int         m_mode, m_age, m_pwm;
    logic [1:0] m_db;
    logic [5:0] e_a, e_z, e_f;
    logic [2:0] e_st;

    rgb_led_sequencer #(.DEBOUNCE_CYCLES(D), .STEP_CYCLES(STEP), .PWM_BITS(3), .DUTY(DUTY_A)) dut_a (
        .clk_125(clk), .rst_n(rst_n), .sw(sw),
        .ld4_r_n(out_a[5]), .ld4_g_n(out_a[4]), .ld4_b_n(out_a[3]),
        .ld5_r_n(out_a[2]), .ld5_g_n(out_a[1]), .ld5_b_n(out_a[0]), .state_o(st_a));
    rgb_led_sequencer #(.DEBOUNCE_CYCLES(D), .STEP_CYCLES(STEP), .PWM_BITS(3), .DUTY(DUTY_Z)) dut_z (
        .clk_125(clk), .rst_n(rst_n), .sw(sw),
        .ld4_r_n(out_z[5]), .ld4_g_n(out_z[4]), .ld4_b_n(out_z[3]),
        .ld5_r_n(out_z[2]), .ld5_g_n(out_z[1]), .ld5_b_n(out_z[0]), .state_o(st_z));
    rgb_led_sequencer #(.DEBOUNCE_CYCLES(D), .STEP_CYCLES(STEP), .PWM_BITS(3), .DUTY(DUTY_F)) dut_f (
        .clk_125(clk), .rst_n(rst_n), .sw(sw),
        .ld4_r_n(out_f[5]), .ld4_g_n(out_f[4]), .ld4_b_n(out_f[3]),
        .ld5_r_n(out_f[2]), .ld5_g_n(out_f[1]), .ld5_b_n(out_f[0]), .state_o(st_f));

    always #5 clk = ~clk;

    // Model: a switch level is adopted once the last D synchronized samples all disagree with it;
    // colour comes from time spent in cycle mode, brightness from time since reset.
    function automatic logic [2:0] model_state();
        if (m_mode == 0) return 3'd0;
        if (m_mode == 1) return 3'd1;
        return 3'(2 + (m_age / STEP) % 3);
    endfunction

    function automatic logic [5:0] out_map(logic [2:0] s, bit on);
        logic [5:0] lit;
        case (s)
            3'd1:    lit = 6'b001001;
            3'd2:    lit = 6'b100010;
            3'd3:    lit = 6'b010001;
            3'd4:    lit = 6'b001100;
            default: lit = 6'b000000;
        endcase
        return on ? ~lit : 6'h3F;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < D + 2; i++) hist.push_back(2'b00);
        m_mode = 0; m_age = 0; m_pwm = 0; m_db = 2'b00;
        e_a = 6'h3F; e_z = 6'h3F; e_f = 6'h3F; e_st = 3'd0;
    endtask

    task automatic tick();
        int         p;
        logic [2:0] s;
        bit         diff;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            s   = model_state();
            p   = m_pwm % PERIOD;
            e_a = out_map(s, p < DUTY_A);
            e_z = out_map(s, p < DUTY_Z);
            e_f = out_map(s, p < DUTY_F);
            if (!m_db[0])          m_mode = 0;
            else if (!m_db[1])     m_mode = 1;
            else if (m_mode != 2) begin m_mode = 2; m_age = 0; end
            else                   m_age++;
            hist.push_front(sw);
            void'(hist.pop_back());
            for (int b = 0; b < 2; b++) begin
                diff = 1'b1;
                for (int j = 2; j < D + 2; j++) if (hist[j][b] == m_db[b]) diff = 1'b0;
                if (diff) m_db[b] = hist[2][b];
            end
            m_pwm++;
            e_st = model_state();
        end
        #1;
    endtask

    task automatic settle_idle();
        sw    = 2'b00;
        rst_n = 1'b0;
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (8) tick();
    endtask

    task automatic test_reset();
        sw    = 2'b11;
        rst_n = 1'b0;
        model_reset();
        repeat (3) begin
            tick();
            n_checks++;
            if ({st_a, out_a, out_z, out_f} !== {3'd0, 18'h3FFFF}) begin
                n_fail++;
                $display("FAIL reset_hold: got %h expected %h", {st_a, out_a, out_z, out_f}, {3'd0, 18'h3FFFF});
            end
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            tick();
            n_checks++;
            if (st_a !== ((e >= 7) ? 3'd2 : 3'd0)) begin
                n_fail++;
                $display("FAIL reset_latency edge %0d: got %0d expected %0d", e, st_a, (e >= 7) ? 2 : 0);
            end
            n_checks++;
            if ({st_a, st_z, st_f, out_a, out_z, out_f} !== {e_st, e_st, e_st, e_a, e_z, e_f}) begin
                n_fail++;
                $display("FAIL reset_model edge %0d: got %h expected %h", e,
                         {st_a, st_z, st_f, out_a, out_z, out_f}, {e_st, e_st, e_st, e_a, e_z, e_f});
            end
        end
        n_checks++;
        if (out_a !== 6'b011101) begin
            n_fail++;
            $display("FAIL reset_first_lit: got %b expected %b", out_a, 6'b011101);
        end
    endtask

    task automatic test_static();
        int lows;
        settle_idle();
        sw = 2'b01;
        for (int e = 1; e <= 7; e++) begin
            tick();
            n_checks++;
            if (st_a !== ((e == 7) ? 3'd1 : 3'd0)) begin
                n_fail++;
                $display("FAIL static_latency edge %0d: got %0d expected %0d", e, st_a, (e == 7) ? 1 : 0);
            end
        end
        tick();
        lows = 0;
        repeat (16) begin
            tick();
            if (out_a[3] === 1'b0) lows++;
            n_checks++;
            if ({out_a[5], out_a[4], out_a[2], out_a[1]} !== 4'hF || out_a[0] !== out_a[3]) begin
                n_fail++;
                $display("FAIL static_channels: got %b expected only b channels lit", out_a);
            end
            n_checks++;
            if ({st_a, st_z, st_f, out_a, out_z, out_f} !== {e_st, e_st, e_st, e_a, e_z, e_f}) begin
                n_fail++;
                $display("FAIL static_model: got %h expected %h",
                         {st_a, st_z, st_f, out_a, out_z, out_f}, {e_st, e_st, e_st, e_a, e_z, e_f});
            end
        end
        n_checks++;
        if (lows !== 8) begin
            n_fail++;
            $display("FAIL static_duty: got %0d low cycles expected 8 in 16", lows);
        end
    endtask

    task automatic test_pwm_bounds();
        int lows_z, lows_f;
        lows_z = 0;
        lows_f = 0;
        repeat (PERIOD) begin
            tick();
            if (out_z[3] === 1'b0) lows_z++;
            if (out_f[3] === 1'b0) lows_f++;
        end
        n_checks++;
        if (lows_z !== 0) begin
            n_fail++;
            $display("FAIL pwm_duty0: got %0d low cycles expected 0", lows_z);
        end
        n_checks++;
        if (lows_f !== 7) begin
            n_fail++;
            $display("FAIL pwm_duty7: got %0d low cycles expected 7", lows_f);
        end
    endtask

    task automatic test_glitch();
        settle_idle();
        sw = 2'b01;
        repeat (3) tick();
        sw = 2'b00;
        repeat (20) begin
            tick();
            n_checks++;
            if ({st_a, out_a, out_z, out_f} !== {3'd0, 18'h3FFFF}) begin
                n_fail++;
                $display("FAIL glitch: got %h expected %h", {st_a, out_a, out_z, out_f}, {3'd0, 18'h3FFFF});
            end
        end
    endtask

    task automatic test_rotation();
        int t;
        sw = 2'b11;
        t  = 0;
        do begin
            tick();
            t++;
        end while (st_a !== 3'd2 && t < 20);
        n_checks++;
        if (st_a !== 3'd2) begin
            n_fail++;
            $display("FAIL rotation_entry: got %0d expected 2 within 20 cycles", st_a);
        end
        for (int i = 1; i < 64; i++) begin
            tick();
            n_checks++;
            if (st_a !== 3'(2 + (i / 16) % 3)) begin
                n_fail++;
                $display("FAIL rotation_step %0d: got %0d expected %0d", i, st_a, 2 + (i / 16) % 3);
            end
            n_checks++;
            if ({st_a, st_z, st_f, out_a, out_z, out_f} !== {e_st, e_st, e_st, e_a, e_z, e_f}) begin
                n_fail++;
                $display("FAIL rotation_model %0d: got %h expected %h", i,
                         {st_a, st_z, st_f, out_a, out_z, out_f}, {e_st, e_st, e_st, e_a, e_z, e_f});
            end
        end
    endtask

    task automatic test_priority();
        int t;
        t = 0;
        while (st_a !== 3'd3 && t < 60) begin
            tick();
            t++;
        end
        repeat (2) tick();
        sw = 2'b00;
        for (int e = 1; e <= 8; e++) begin
            tick();
            n_checks++;
            if (st_a === 3'd1 || (e < 7 && st_a !== 3'd3) || (e >= 7 && st_a !== 3'd0)) begin
                n_fail++;
                $display("FAIL priority_state edge %0d: got %0d expected %0d", e, st_a, (e < 7) ? 3 : 0);
            end
        end
        n_checks++;
        if ({out_a, out_z, out_f} !== 18'h3FFFF) begin
            n_fail++;
            $display("FAIL priority_outputs: got %h expected 3ffff", {out_a, out_z, out_f});
        end
        sw = 2'b11;
        t  = 0;
        while (out_a === 6'h3F && t < 40) begin
            tick();
            t++;
        end
        n_checks++;
        if (out_a === 6'h3F) begin
            n_fail++;
            $display("FAIL async_setup: got %h expected lit output", out_a);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({st_a, out_a, out_z, out_f} !== {3'd0, 18'h3FFFF}) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected %h", {st_a, out_a, out_z, out_f}, {3'd0, 18'h3FFFF});
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        int hold;
        for (int seg = 0; seg < 40; seg++) begin
            sw   = 2'($urandom_range(0, 3));
            hold = $urandom_range(1, 24);
            repeat (hold) begin
                tick();
                n_checks++;
                if ({st_a, st_z, st_f, out_a, out_z, out_f} !== {e_st, e_st, e_st, e_a, e_z, e_f}) begin
                    n_fail++;
                    $display("FAIL random_model seg %0d: got %h expected %h", seg,
                             {st_a, st_z, st_f, out_a, out_z, out_f}, {e_st, e_st, e_st, e_a, e_z, e_f});
                end
            end
        end
    endtask

    initial begin
        model_reset();
        #1;
        test_reset();
        test_static();
        test_pwm_bounds();
        test_glitch();
        test_rotation();
        test_priority();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
